// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the LEGv8 fetch stage, control decoder and bench:
// FSM encoding, default reset PC and the 11-bit opcode patterns.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } fetch_state_t;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;
  localparam int          OPCODE_W         = 11;

  // Exact opcodes (Instruction[31:21])
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;

  // Opcodes whose low bits belong to the immediate field: pattern + care mask
  localparam logic [10:0] OP_CBZ   = 11'h5A0;
  localparam logic [10:0] MASK_CBZ = 11'h7F8;
  localparam logic [10:0] OP_B     = 11'h0A0;
  localparam logic [10:0] MASK_B   = 11'h7E0;

  // True when the opcode matches the pattern on every bit selected by mask
  function automatic logic opcode_match(input logic [10:0] op,
                                        input logic [10:0] pattern,
                                        input logic [10:0] mask);
    return ((op ^ pattern) & mask) == 11'h000;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_next_pc.sv
// Next-PC selection: sequential PC+4 or PC-relative branch target.
// Arithmetic wraps modulo 2^ADDR_W and the result is always word aligned.
module next_pc_logic #(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] PC,
  input  logic [ADDR_W-1:0] BranchOffset,
  input  logic              Branch,
  input  logic              Uncondbranch,
  input  logic              Zero,
  output logic [ADDR_W-1:0] NextPC
);

  logic              pcsrc;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] target_pc;
  logic [ADDR_W-1:0] sel_pc;

  // Uncondbranch is ORed first so an unknown Branch during B resolves to 1
  always_comb begin
    pcsrc     = Uncondbranch | (Branch & Zero);
    seq_pc    = PC + ADDR_W'(4);
    target_pc = PC + (BranchOffset << 2);
    sel_pc    = pcsrc ? target_pc : seq_pc;
    NextPC    = sel_pc & ~ADDR_W'(3);
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// LEGv8 fetch stage: holds PC, fetches one instruction per execution slot
// over a req/ack port, presents it to control and advances PC on commit.
// Handshake: imem_req is high for the whole FETCH state with imem_addr held
// at PC; the instruction is taken on the first edge where imem_ack is high
// in FETCH. commit is honoured only while instr_valid is high (EXEC).
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               CLK,
  input  logic               Reset_L,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               Branch,
  input  logic               Uncondbranch,
  input  logic               Zero,
  input  logic [ADDR_W-1:0]  BranchOffset,
  input  logic               commit,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] Instruction,
  output logic [10:0]        Opcode,
  output logic [ADDR_W-1:0]  CurrentPC,
  output logic [31:0]        retired_cnt,
  output logic [1:0]         state_dbg
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic              take_ack;
  logic              take_commit;

  next_pc_logic #(.ADDR_W(ADDR_W)) u_next_pc (
    .PC           (pc),
    .BranchOffset (BranchOffset),
    .Branch       (Branch),
    .Uncondbranch (Uncondbranch),
    .Zero         (Zero),
    .NextPC       (next_pc)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!Reset_L) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: if (imem_ack) state_nxt = ST_EXEC;
      ST_EXEC:  if (commit)   state_nxt = ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs and the qualified ack/commit strobes
  always_comb begin
    imem_req    = (state == ST_FETCH);
    instr_valid = (state == ST_EXEC);
    take_ack    = (state == ST_FETCH) && imem_ack;
    take_commit = (state == ST_EXEC) && commit;
  end

  // PC, instruction register and retired counter
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      pc          <= RESET_PC & ~ADDR_W'(3);
      Instruction <= '0;
      retired_cnt <= '0;
    end else begin
      if (take_ack)    Instruction <= imem_rdata;
      if (take_commit) begin
        pc          <= next_pc;
        retired_cnt <= retired_cnt + 32'd1;
      end
    end
  end

  // Datapath-facing views of the registers
  always_comb begin
    imem_addr = pc;
    CurrentPC = pc;
    Opcode    = Instruction[INSTR_W-1 -: OPCODE_W];
    state_dbg = state;
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios then random
// fetch/commit traffic against a PC/count model; a monitor compares
// fetch addresses and presented instructions with expected queues.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam int          ADDR_W = 64;
  localparam int          INSTR_W = 32;
  localparam logic [63:0] RST_PC = DEFAULT_RESET_PC;

  logic               CLK = 1'b0;
  logic               Reset_L = 1'b0;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack = 1'b0;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               Branch = 1'b0;
  logic               Uncondbranch = 1'b0;
  logic               Zero = 1'b0;
  logic [ADDR_W-1:0]  BranchOffset = '0;
  logic               commit = 1'b0;
  logic               instr_valid;
  logic [INSTR_W-1:0] Instruction;
  logic [10:0]        Opcode;
  logic [ADDR_W-1:0]  CurrentPC;
  logic [31:0]        retired_cnt;
  logic [1:0]         state_dbg;

  instruction_fetch_unit dut (
    .CLK(CLK), .Reset_L(Reset_L), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .Branch(Branch),
    .Uncondbranch(Uncondbranch), .Zero(Zero), .BranchOffset(BranchOffset),
    .commit(commit), .instr_valid(instr_valid), .Instruction(Instruction),
    .Opcode(Opcode), .CurrentPC(CurrentPC), .retired_cnt(retired_cnt),
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_instr_q[$];
  logic [63:0] exp_addr_q[$];
  int          checks = 0;
  int          passed = 0;

  // Reference model state
  logic [63:0] m_pc = RST_PC;
  logic [31:0] m_cnt = 0;
  logic [31:0] m_instr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: new requests and newly presented instructions
  logic        prev_req = 1'b0;
  logic        prev_valid = 1'b0;
  logic        have_held = 1'b0;
  logic [63:0] held_addr = '0;
  exp_t        e;
  always @(negedge CLK) begin
    if (imem_req && !prev_req) begin
      if (exp_addr_q.size() == 0) fail_now("unexpected_fetch");
      else begin
        held_addr = exp_addr_q.pop_front();
        have_held = 1'b1;
        chk("fetch_addr", imem_addr, held_addr);
      end
    end else if (imem_req && have_held) begin
      chk("addr_stable", imem_addr, held_addr);
    end
    if (instr_valid && !prev_valid) begin
      if (exp_instr_q.size() == 0) fail_now("unexpected_instr_valid");
      else begin
        e = exp_instr_q.pop_front();
        chk("instruction", 64'(Instruction), 64'(e.instr));
        chk("opcode", 64'(Opcode), 64'(e.instr[31:21]));
        chk("current_pc", CurrentPC, e.pc);
        chk("retired_cnt", 64'(retired_cnt), 64'(e.cnt));
      end
    end
    prev_req   = imem_req;
    prev_valid = instr_valid;
  end

  // Reset, optionally with a stale ack presented on the first released edge
  task automatic do_reset(input bit stale_ack);
    Reset_L = 1'b0; imem_ack = 1'b0; commit = 1'b0;
    @(posedge CLK); #1;
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_opcode", 64'(Opcode), 64'd0);
    chk("rst_instr", 64'(Instruction), 64'd0);
    chk("rst_pc", CurrentPC, RST_PC);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_cnt", 64'(retired_cnt), 64'd0);
    m_pc = RST_PC; m_cnt = 0; m_instr = 0;
    exp_addr_q.delete(); exp_instr_q.delete();
    exp_addr_q.push_back(m_pc);
    Reset_L = 1'b1;
    if (stale_ack) begin
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      @(posedge CLK); #1;
      imem_ack = 1'b0;
      chk("stale_ack_ignored", 64'(instr_valid), 64'd0);
      chk("stale_ack_instr", 64'(Instruction), 64'd0);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      @(posedge CLK); #1; n++;
    end
    if (!imem_req) fail_now("req_timeout");
  endtask

  task automatic fetch(input logic [31:0] rdata, input int waits, input bit commit_in_wait);
    wait_req();
    for (int i = 0; i < waits; i++) begin
      if (commit_in_wait && i == 1) begin
        commit = 1'b1; Uncondbranch = 1'b1; BranchOffset = 64'd100;
      end
      @(posedge CLK); #1;
      commit = 1'b0; Uncondbranch = 1'b0;
      chk("req_held", 64'(imem_req), 64'd1);
      chk("no_valid_wait", 64'(instr_valid), 64'd0);
    end
    imem_rdata = rdata; imem_ack = 1'b1;
    m_instr = rdata;
    exp_instr_q.push_back('{instr: rdata, pc: m_pc, cnt: m_cnt});
    @(posedge CLK); #1;
    imem_ack = 1'b0; imem_rdata = $urandom;
    chk("valid_latency", 64'(instr_valid), 64'd1);
  endtask

  task automatic do_commit(input bit br, input bit ub, input bit z,
                           input logic [63:0] off, input int idle, input bit br_x);
    for (int i = 0; i < idle; i++) begin
      imem_ack = 1'b1; imem_rdata = $urandom;
      @(posedge CLK); #1;
      imem_ack = 1'b0;
    end
    if (idle > 0) begin
      chk("instr_hold", 64'(Instruction), 64'(m_instr));
      chk("pc_hold", CurrentPC, m_pc);
    end
    Branch = br_x ? 1'bx : br; Uncondbranch = ub; Zero = z; BranchOffset = off;
    commit = 1'b1;
    @(posedge CLK); #1;
    commit = 1'b0; Branch = 1'b0; Uncondbranch = 1'b0;
    if (ub || (br && z)) m_pc = m_pc + off * 64'd4;
    else                 m_pc = m_pc + 64'd4;
    m_cnt = m_cnt + 1;
    exp_addr_q.push_back(m_pc);
    chk("valid_drop", 64'(instr_valid), 64'd0);
  endtask

  logic [10:0] ops [8] = '{OP_LDUR, OP_STUR, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_CBZ, OP_B};

  initial begin
    int o;
    logic signed [63:0] offs;
    logic [10:0] op;

    // LDUR at reset PC, immediate ack
    do_reset(1'b0);
    fetch(32'hF84003E9, 0, 1'b0);
    chk("ldur_opcode", 64'(Opcode), 64'(OP_LDUR));
    do_commit(0, 0, 0, 64'd0, 0, 0);                       // -> 4
    fetch({OP_ADD, 21'h0_1234}, 0, 1'b0);
    do_commit(0, 0, 0, 64'd0, 1, 0);                       // -> 8
    fetch({OP_CBZ, 21'h0_0060}, 1, 1'b0);
    chk("cbz_match", 64'(opcode_match(Opcode, OP_CBZ, MASK_CBZ)), 64'd1);
    do_commit(1, 0, 1, 64'd3, 0, 0);                       // taken -> 20
    fetch({OP_B, 21'h1F_FFFD}, 0, 1'b0);
    do_commit(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0);     // -> 8
    fetch({OP_CBZ, 21'h0_0060}, 0, 1'b0);
    do_commit(1, 0, 0, 64'd3, 0, 0);                       // not taken -> 12
    fetch({OP_SUB, 21'h0_0042}, 0, 1'b0);
    do_commit(0, 0, 0, 64'd0, 0, 0);                       // -> 16
    fetch({OP_B, 21'h1F_FFFE}, 0, 1'b0);
    do_commit(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1);     // Branch=X -> 8
    // Five wait cycles with a stray commit pulse
    fetch({OP_ORR, 21'h0_0777}, 5, 1'b1);
    do_commit(0, 0, 0, 64'd0, 0, 0);                       // -> 12

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 7)];
      fetch({op, 21'($urandom)}, $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
      o = int'($urandom_range(0, 16)) - 8;
      offs = o;
      do_commit(1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
                offs, $urandom_range(0, 2), 0);
    end

    // Reset in the middle of a fetch at 0x40, stale ack afterwards
    do_reset(1'b0);
    fetch({OP_B, 21'h00_0010}, 0, 1'b0);
    do_commit(0, 1, 0, 64'd16, 0, 0);                      // -> 0x40
    wait_req();
    #10;
    do_reset(1'b1);

    // Wrap: branch back one word to the top of memory, then step over it
    fetch({OP_B, 21'h1F_FFFF}, 0, 1'b0);
    do_commit(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);     // -> FF..FC
    fetch({OP_STUR, 21'h0_0001}, 0, 1'b0);
    do_commit(0, 0, 0, 64'd0, 0, 0);                       // wraps -> 0
    fetch({OP_AND, 21'h0_0002}, 1, 1'b0);
    chk("wrap_pc", CurrentPC, 64'd0);

    repeat (2) @(posedge CLK);
    #1;
    chk("final_cnt", 64'(retired_cnt), 64'(m_cnt));
    chk("addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
    chk("instr_q_empty", 64'(exp_instr_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Safety net against a stuck run
  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
